// File: rtl/key_scan_ctrl_if.sv
// Keypad matrix bundle: row sense in, column drive and key events out.
interface key_scan_ctrl_if;
  logic [3:0] key_row;
  logic [3:0] key_col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;

  // Scan controller side
  modport master (
    input  key_row,
    output key_col,
    output key_code,
    output key_valid,
    output key_down
  );

  // Keypad / event consumer side
  modport slave (
    output key_row,
    input  key_col,
    input  key_code,
    input  key_valid,
    input  key_down
  );
endinterface

// File: rtl/key_scan_ctrl.sv
// 4x4 keypad scanner: rotates one-hot column drive, samples synchronized rows at the end of
// each column dwell, debounces the per-scan key code and reports press pulses / held level.
module key_scan_ctrl #(
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic            HIGH_CLK,
  input  logic            nRST,
  key_scan_ctrl_if.master kbd_io
);

  localparam int unsigned     DivW     = $clog2(SCAN_DIV);
  localparam logic [DivW-1:0] DivLast  = DivW'(SCAN_DIV - 1);
  localparam logic [3:0]      DbTarget = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {StIdle, StDebounce, StPressed, StRelease} state_e;

  logic [3:0]      row_meta_q, row_sync_q;
  logic [DivW-1:0] div_q, div_d;
  logic [1:0]      col_idx_q, col_idx_d;
  logic [3:0]      key_col_q, key_col_d;
  logic            acc_hit_q, acc_hit_d, acc_multi_q, acc_multi_d;
  logic [3:0]      acc_code_q, acc_code_d;
  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d, cand_q, cand_d, key_code_q, key_code_d;
  logic            key_valid_q, key_valid_d;

  logic            sample_pt, scan_end;
  logic            row_hit, row_multi;
  logic [1:0]      row_idx;
  logic            col_hit, col_multi;
  logic [3:0]      col_code;
  logic            scan_none, scan_single;
  logic [3:0]      cnt_inc;

  assign sample_pt = (div_q == DivLast);
  assign scan_end  = sample_pt && (col_idx_q == 2'd3);

  // Current column's row sample folded into the running scan result
  assign row_hit   = |row_sync_q;
  assign row_multi = (row_sync_q & (row_sync_q - 4'd1)) != 4'd0;
  assign row_idx   = {row_sync_q[3] | row_sync_q[2], row_sync_q[3] | row_sync_q[1]};
  assign col_hit   = acc_hit_q | row_hit;
  assign col_multi = acc_multi_q | row_multi | (acc_hit_q & row_hit);
  assign col_code  = (row_hit && !acc_hit_q) ? {col_idx_q, row_idx} : acc_code_q;

  assign scan_none   = !col_hit;
  assign scan_single = col_hit && !col_multi;
  assign cnt_inc     = (cnt_q == 4'hF) ? 4'hF : cnt_q + 4'd1;

  // Dwell counter, column rotation and per-scan accumulator next state
  always_comb begin
    div_d      = sample_pt ? '0 : div_q + DivW'(1);
    col_idx_d  = sample_pt ? col_idx_q + 2'd1 : col_idx_q;
    key_col_d  = 4'b0001 << col_idx_d;
    acc_hit_d  = acc_hit_q;
    acc_multi_d = acc_multi_q;
    acc_code_d = acc_code_q;
    if (scan_end) begin
      acc_hit_d   = 1'b0;
      acc_multi_d = 1'b0;
      acc_code_d  = 4'd0;
    end else if (sample_pt) begin
      acc_hit_d   = col_hit;
      acc_multi_d = col_multi;
      acc_code_d  = col_code;
    end
  end

  // Debounce FSM next state, evaluated only on scan-end cycles
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cand_d      = cand_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    if (scan_end) begin
      unique case (state_q)
        StIdle: begin
          if (scan_single) begin
            cand_d = col_code;
            if (DbTarget <= 4'd1) begin
              state_d     = StPressed;
              key_code_d  = col_code;
              key_valid_d = 1'b1;
              cnt_d       = 4'd0;
            end else begin
              state_d = StDebounce;
              cnt_d   = 4'd1;
            end
          end
        end
        StDebounce: begin
          if (scan_single && (col_code == cand_q)) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= DbTarget) begin
              state_d     = StPressed;
              key_code_d  = cand_q;
              key_valid_d = 1'b1;
              cnt_d       = 4'd0;
            end
          end else begin
            state_d = StIdle;
            cnt_d   = 4'd0;
          end
        end
        StPressed: begin
          // A second key while held is ignored; only a clean scan starts release
          if (scan_none) begin
            if (DbTarget <= 4'd1) begin
              state_d = StIdle;
              cnt_d   = 4'd0;
            end else begin
              state_d = StRelease;
              cnt_d   = 4'd1;
            end
          end
        end
        StRelease: begin
          if (scan_none) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= DbTarget) begin
              state_d = StIdle;
              cnt_d   = 4'd0;
            end
          end else begin
            state_d = StPressed;
            cnt_d   = 4'd0;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  // Row synchronizer, scan sequencing and FSM registers
  always_ff @(posedge HIGH_CLK or negedge nRST) begin
    if (!nRST) begin
      row_meta_q  <= 4'd0;
      row_sync_q  <= 4'd0;
      div_q       <= '0;
      col_idx_q   <= 2'd0;
      key_col_q   <= 4'b0001;
      acc_hit_q   <= 1'b0;
      acc_multi_q <= 1'b0;
      acc_code_q  <= 4'd0;
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      cand_q      <= 4'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
    end else begin
      row_meta_q  <= kbd_io.key_row;
      row_sync_q  <= row_meta_q;
      div_q       <= div_d;
      col_idx_q   <= col_idx_d;
      key_col_q   <= key_col_d;
      acc_hit_q   <= acc_hit_d;
      acc_multi_q <= acc_multi_d;
      acc_code_q  <= acc_code_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign kbd_io.key_col   = key_col_q;
  assign kbd_io.key_code  = key_code_q;
  assign kbd_io.key_valid = key_valid_q;
  assign kbd_io.key_down  = (state_q == StPressed) || (state_q == StRelease);

endmodule

// File: tb/tb_key_scan_ctrl.sv
// Directed bench for key_scan_ctrl with SCAN_DIV=4, DEBOUNCE_SCANS=3 (16-cycle scans).
module tb_key_scan_ctrl;

  logic        clk = 1'b0;
  logic        nRST;
  logic [15:0] keys;
  logic [3:0]  row_model;

  int unsigned cyc = 0;
  int unsigned valid_pulses = 0;
  logic        prev_valid = 1'b0;
  logic        double_valid = 1'b0;
  int          errors = 0;
  int          checks = 0;

  key_scan_ctrl_if ks_if ();

  key_scan_ctrl #(
    .SCAN_DIV      (4),
    .DEBOUNCE_SCANS(3)
  ) dut (
    .HIGH_CLK(clk),
    .nRST    (nRST),
    .kbd_io  (ks_if.master)
  );

  always #5 clk = ~clk;

  // Key matrix: row r is high when any pressed key (c,r) has its column driven
  always_comb begin
    row_model = 4'd0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[c*4+r] && ks_if.key_col[c]) row_model[r] = 1'b1;
      end
    end
  end
  assign ks_if.key_row = row_model;

  // Cycles since reset release; scan ends fall on multiples of 16
  always @(posedge clk or negedge nRST) begin
    if (!nRST) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Pulse counter and back-to-back pulse detector
  always @(posedge clk) begin
    if (ks_if.key_valid) begin
      valid_pulses <= valid_pulses + 1;
      if (prev_valid) double_valid <= 1'b1;
    end
    prev_valid <= ks_if.key_valid;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic next_scan_end();
    @(negedge clk);
    while (cyc % 16 != 0) @(negedge clk);
  endtask

  initial begin
    nRST = 1'b0;
    keys = 16'd0;
    repeat (3) @(negedge clk);
    nRST = 1'b1;

    // Reset state and column rotation with no keys
    check("reset_col", 32'(ks_if.key_col), 32'h1);
    check("reset_code", 32'(ks_if.key_code), 32'h0);
    check("reset_valid", 32'(ks_if.key_valid), 32'h0);
    check("reset_down", 32'(ks_if.key_down), 32'h0);
    repeat (4) @(negedge clk);
    check("col_1", 32'(ks_if.key_col), 32'h2);
    repeat (4) @(negedge clk);
    check("col_2", 32'(ks_if.key_col), 32'h4);
    repeat (4) @(negedge clk);
    check("col_3", 32'(ks_if.key_col), 32'h8);
    repeat (4) @(negedge clk);
    check("col_wrap", 32'(ks_if.key_col), 32'h1);
    check("idle_pulses", valid_pulses, 32'd0);
    check("idle_down", 32'(ks_if.key_down), 32'h0);

    // Hold key (2,1) -> code 9 after three scans
    keys = 16'h1 << 9;
    next_scan_end();
    next_scan_end();
    check("deb_valid", 32'(ks_if.key_valid), 32'h0);
    check("deb_down", 32'(ks_if.key_down), 32'h0);
    next_scan_end();
    check("press_valid", 32'(ks_if.key_valid), 32'h1);
    check("press_code", 32'(ks_if.key_code), 32'h9);
    check("press_down", 32'(ks_if.key_down), 32'h1);

    // One-scan release glitch, re-press, then a clean three-scan release
    keys = 16'd0;
    @(negedge clk);
    check("press_pulse_end", 32'(ks_if.key_valid), 32'h0);
    check("press_pulses", valid_pulses, 32'd1);
    next_scan_end();
    check("glitch_down", 32'(ks_if.key_down), 32'h1);
    keys = 16'h1 << 9;
    next_scan_end();
    check("repress_down", 32'(ks_if.key_down), 32'h1);
    keys = 16'd0;
    next_scan_end();
    next_scan_end();
    check("rel2_down", 32'(ks_if.key_down), 32'h1);
    next_scan_end();
    check("rel3_down", 32'(ks_if.key_down), 32'h0);
    check("glitch_pulses", valid_pulses, 32'd1);
    check("glitch_code", 32'(ks_if.key_code), 32'h9);

    // Key (1,3) seen for only two scans
    keys = 16'h1 << 7;
    next_scan_end();
    next_scan_end();
    keys = 16'd0;
    next_scan_end();
    next_scan_end();
    check("short_pulses", valid_pulses, 32'd1);
    check("short_code", 32'(ks_if.key_code), 32'h9);
    check("short_down", 32'(ks_if.key_down), 32'h0);

    // Keys (0,0)+(1,1) together: MULTI, then (0,0) alone gets accepted
    keys = (16'h1 << 0) | (16'h1 << 5);
    repeat (4) next_scan_end();
    check("multi_pulses", valid_pulses, 32'd1);
    check("multi_down", 32'(ks_if.key_down), 32'h0);
    keys = 16'h1 << 0;
    next_scan_end();
    next_scan_end();
    check("single0_deb_down", 32'(ks_if.key_down), 32'h0);
    next_scan_end();
    check("single0_valid", 32'(ks_if.key_valid), 32'h1);
    check("single0_code", 32'(ks_if.key_code), 32'h0);
    check("single0_down", 32'(ks_if.key_down), 32'h1);

    // Release, accept code 9 again, then reset asynchronously mid-PRESSED
    keys = 16'd0;
    repeat (3) next_scan_end();
    check("rel0_down", 32'(ks_if.key_down), 32'h0);
    keys = 16'h1 << 9;
    repeat (3) next_scan_end();
    check("again_code", 32'(ks_if.key_code), 32'h9);
    repeat (6) @(negedge clk);
    nRST = 1'b0;
    #1;
    check("arst_col", 32'(ks_if.key_col), 32'h1);
    check("arst_code", 32'(ks_if.key_code), 32'h0);
    check("arst_valid", 32'(ks_if.key_valid), 32'h0);
    check("arst_down", 32'(ks_if.key_down), 32'h0);
    @(negedge clk);
    nRST = 1'b1;
    check("arst_pulses", valid_pulses, 32'd3);

    // Key still held: fresh debounce after reset
    next_scan_end();
    next_scan_end();
    check("post_rst_valid", 32'(ks_if.key_valid), 32'h0);
    check("post_rst_down", 32'(ks_if.key_down), 32'h0);
    next_scan_end();
    check("post_rst_press", 32'(ks_if.key_valid), 32'h1);
    check("post_rst_code", 32'(ks_if.key_code), 32'h9);
    check("post_rst_kdown", 32'(ks_if.key_down), 32'h1);
    @(negedge clk);
    check("post_rst_pulse_end", 32'(ks_if.key_valid), 32'h0);
    check("final_pulses", valid_pulses, 32'd4);
    check("no_double_pulse", 32'(double_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_scan_ctrl.md
# key_scan_ctrl

Sequencing controller for the 4x4 matrix keypad of the calendar. It drives the column lines one-hot in rotation and samples the row lines at the end of each column dwell. It debounces the resulting per-scan key code over several full scans and reports one pulse per debounced press, plus a held-key level. It replaces ad-hoc column driving and feeds key events to the calendar mode/set logic on the HIGH_CLK domain.

## Interface
- SCAN_DIV, 1000: HIGH_CLK cycles per column dwell; must be >= 3.
- DEBOUNCE_SCANS, 4: consecutive full scans required to accept a press or a release; must be >= 1, max 15.

- HIGH_CLK  input  1  sole clock, all state on rising edge.
- nRST  input  1  asynchronous, active-low reset.
- key_row  input  4  row lines, active high; asynchronous to HIGH_CLK.
- key_col  output  4  column drive, one-hot, active high.
- key_code  output  4  code of accepted key = col_index*4 + row_index (col_index 0 ↔ key_col=0001, row_index n ↔ key_row[n]).
- key_valid  output  1  one-cycle pulse on each accepted press.
- key_down  output  1  high while an accepted key is held.

## Operation
- key_row passes through a 2-flop synchronizer before any use.
- Dwell counter div_cnt counts 0..SCAN_DIV-1 and wraps. col_idx (0..3) advances on wrap. key_col = 1<<col_idx, registered.
- Sample point: the cycle with div_cnt==SCAN_DIV-1. The synchronized row is evaluated against the current col_idx.
- Per-scan result accumulates over the 4 sample points as NONE, SINGLE(code), or MULTI. MULTI means more than one row bit in a column, or hits in more than one column. The result is evaluated at scan end (sample point with col_idx==3), then cleared.
- FSM, updated only at scan end:
  - IDLE: SINGLE(c) → DEBOUNCE, cand=c, cnt=1. Else stay. If DEBOUNCE_SCANS==1, go directly to PRESSED.
  - DEBOUNCE: SINGLE(cand) → cnt+1. When cnt reaches DEBOUNCE_SCANS → PRESSED, key_code=cand, pulse key_valid. Any other result → IDLE, cnt=0.
  - PRESSED: NONE → RELEASE, cnt=1 (IDLE directly if DEBOUNCE_SCANS==1). SINGLE or MULTI → stay; a second key never generates an event.
  - RELEASE: NONE → cnt+1. When cnt reaches DEBOUNCE_SCANS → IDLE. Non-NONE → PRESSED, no new key_valid.
- key_down = 1 in PRESSED and RELEASE, 0 in IDLE and DEBOUNCE.
- key_code holds its last accepted value until the next accepted press.
- cnt is 4 bits and saturates; it never wraps.

## Timing
- Reset values: key_col=0001, key_code=0, key_valid=0, key_down=0, state IDLE, div_cnt=0, col_idx=0, synchronizer and scan accumulator cleared.
- Reset is asynchronous on assertion and takes effect immediately, including mid-DEBOUNCE or mid-PRESSED. After deassertion, scanning restarts at column 0 with a fresh scan.
- key_col changes one cycle after the div_cnt wrap edge. SCAN_DIV >= 3 guarantees the synchronized row reflects the current column at the sample point.
- Full scan = 4*SCAN_DIV cycles.
- key_valid is high for exactly the one cycle after the scan-end edge that completes debounce. It never stays high for two consecutive cycles.
- key_down rises in the same cycle as key_valid. It falls the cycle after the scan-end edge that completes release.
- Press latency: DEBOUNCE_SCANS scan ends at which the key is visible, plus up to 1 scan of alignment.

## Test plan
Bench config: SCAN_DIV=4, DEBOUNCE_SCANS=3, scan = 16 cycles. The key model drives key_row[r]=1 whenever key_col[c]=1.

- Reset, no keys → key_col=0001 after reset; becomes 0010 after 4 cycles, 0100 after 8, 1000 after 12, and 0001 again after 16. key_valid, key_down and key_code stay 0.
- Hold key (c=2,r=1) → exactly one key_valid pulse after the 3rd scan end with key visible; key_code=9 and key_down=1 from that cycle.
- Key (c=1,r=3) visible for 2 scans, then released → no key_valid; key_code remains at its prior value.
- Keys (0,0) and (1,1) held together from IDLE → MULTI every scan, no key_valid ever. Releasing (1,1) then leaves code 0 accepted after 3 scans.
- After accepted press of code 9: release for 1 scan, re-press, then release for 3 scans → no second key_valid. key_down stays 1 through the glitch and drops after the 3rd clean scan.
- nRST pulsed low for 1 cycle during DEBOUNCE or PRESSED → all outputs at reset values immediately. Key still held → new key_valid after 3 full scans.
